// File: rtl/controller_uart1_rd_status_if.sv
// Avalon-MM slave bus bundle for the UART1 read-status port.
// The master drives the address and strobes. The slave returns the read data and the interrupt.
interface controller_uart1_rd_status_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic        read_n;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      output read_n,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      input  read_n,
      output readdata,
      output irq
   );
endinterface

// File: rtl/controller_uart1_rd_status.sv
// UART1 read-status port.
// Each status bit passes through a two-flop synchronizer and then a stable-count deglitch filter.
// Qualifying filtered edges set sticky capture flags, and the flags drive a maskable level interrupt.
module controller_uart1_rd_status #(
   parameter int WIDTH         = 2,
   parameter int EDGE_TYPE     = 0,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   controller_uart1_rd_status_if.slave bus,
   input  logic [WIDTH-1:0]           in_port
);

   localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

   logic [WIDTH-1:0]       s1;
   logic [WIDTH-1:0]       s2;
   logic [WIDTH-1:0]       filt;
   logic [WIDTH-1:0]       filt_next;
   logic [WIDTH-1:0][7:0]  cnt;
   logic [WIDTH-1:0][7:0]  cnt_next;
   logic [WIDTH-1:0]       accept;
   logic [WIDTH-1:0]       ev;
   logic [WIDTH-1:0]       irq_mask;
   logic [WIDTH-1:0]       mask_next;
   logic [WIDTH-1:0]       edge_capture;
   logic [WIDTH-1:0]       cap_next;
   logic [WIDTH-1:0]       clr_bits;
   logic                   wr_en;
   logic                   rd_en;
   logic [31:0]            rd_mux;
   logic                   unused_ok;

   // The upper writedata bits have no register behind them.
   assign unused_ok = ^bus.writedata;

   // Two-flop synchronizer that brings the asynchronous status inputs into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

   // Per-bit stable-count filter: a new value must persist for FILTER_CYCLES clocks to be accepted.
   always_comb begin
      filt_next = filt;
      cnt_next  = cnt;
      accept    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (s2[i] == filt[i]) begin
            cnt_next[i] = 8'd0;
         end else if (cnt[i] == CNT_LAST) begin
            filt_next[i] = s2[i];
            cnt_next[i]  = 8'd0;
            accept[i]    = 1'b1;
         end else begin
            cnt_next[i] = cnt[i] + 8'd1;
         end
      end
   end

   // Filter state registers. A reset discards any partially counted run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         filt <= '0;
         cnt  <= '0;
      end else begin
         filt <= filt_next;
         cnt  <= cnt_next;
      end
   end

   // Select which accepted transitions count as events: rising, falling, or both.
   always_comb begin
      ev = '0;
      if (EDGE_TYPE == 0) begin
         ev = accept & filt_next;
      end else if (EDGE_TYPE == 1) begin
         ev = accept & ~filt_next;
      end else begin
         ev = accept;
      end
   end

   // Bus decode and next-state logic for the mask and capture registers. A new event beats a clear.
   always_comb begin
      wr_en     = bus.chipselect && !bus.write_n;
      rd_en     = bus.chipselect && !bus.read_n;
      mask_next = irq_mask;
      clr_bits  = '0;
      if (wr_en && bus.address == 3'd2) begin
         mask_next = bus.writedata[WIDTH-1:0];
      end
      if (wr_en && bus.address == 3'd3) begin
         clr_bits = bus.writedata[WIDTH-1:0];
      end
      cap_next = (edge_capture & ~clr_bits) | ev;
   end

   // Read mux built from the values before this edge's update, zero-extended to 32 bits.
   always_comb begin
      rd_mux = '0;
      case (bus.address)
         3'd0:    rd_mux[WIDTH-1:0] = filt;
         3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
         3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
         default: rd_mux = '0;
      endcase
   end

   // Register file, registered read data, and an interrupt that follows the flags by one clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask     <= '0;
         edge_capture <= '0;
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         irq_mask     <= mask_next;
         edge_capture <= cap_next;
         bus.irq      <= |(edge_capture & irq_mask);
         if (rd_en) begin
            bus.readdata <= rd_mux;
         end
      end
   end

endmodule
